// File: rtl/seq_mult_hs.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_SIGNED_EN to compile in the per-transaction signed mode (in_signed_i).
module seq_mult_hs #(
    parameter int N = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   in_a_i,
    input  logic [N-1:0]   in_b_i,
    input  logic           in_signed_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] result_o,
    output logic           overflow_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q;
    logic [N-1:0]   mcand_q;
    logic [2*N:0]   acc_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] result_q;
    logic           overflow_q;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     sum;
    logic [2*N:0]   acc_d;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] result_d;
    logic           overflow_d;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic signed_q;
`else
    logic unused_signed;
    assign unused_signed = in_signed_i;
`endif

    // The accumulator's upper half carries one extra bit so the add never loses a carry.
    always_comb begin
        sum   = acc_q[2*N:N] + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        acc_d = {sum, acc_q[N-1:0]} >> 1;
        prod  = acc_d[2*N-1:0];
`ifdef SEQ_MULT_SIGNED_EN
        a_mag      = (in_signed_i && in_a_i[N-1]) ? -in_a_i : in_a_i;
        b_mag      = (in_signed_i && in_b_i[N-1]) ? -in_b_i : in_b_i;
        result_d   = neg_q ? -prod : prod;
        overflow_d = signed_q
                   ? ~((&result_d[2*N-1:N-1]) | ~(|result_d[2*N-1:N-1]))
                   : (|result_d[2*N-1:N]);
`else
        a_mag      = in_a_i;
        b_mag      = in_b_i;
        result_d   = prod;
        overflow_d = |prod[2*N-1:N];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q      <= 1'b0;
            signed_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        mcand_q  <= a_mag;
                        acc_q    <= {{(N+1){1'b0}}, b_mag};
                        cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_q    <= in_signed_i & (in_a_i[N-1] ^ in_b_i[N-1]);
                        signed_q <= in_signed_i;
`endif
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_q   <= result_d;
                        overflow_q <= overflow_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed N=8 checks plus a randomised N=32 regression against an arithmetic reference model.
// Signed cases are exercised only when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult_hs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, in_signed8 = 1'b0;
    logic [7:0]  in_a8 = '0, in_b8 = '0;
    logic        out_valid8, out_ready8 = 1'b0, overflow8;
    logic [15:0] result8;

    logic        in_valid32 = 1'b0, in_ready32, in_signed32 = 1'b0;
    logic [31:0] in_a32 = '0, in_b32 = '0;
    logic        out_valid32, out_ready32 = 1'b0, overflow32;
    logic [63:0] result32;

    int checks = 0;
    int errors = 0;

    seq_mult_hs #(.N(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .in_a_i(in_a8), .in_b_i(in_b8), .in_signed_i(in_signed8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .result_o(result8), .overflow_o(overflow8)
    );

    seq_mult_hs #(.N(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .in_a_i(in_a32), .in_b_i(in_b32), .in_signed_i(in_signed32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready32),
        .result_o(result32), .overflow_o(overflow32)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge while IDLE; returns at the first negedge after the accept edge.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s);
        checkOutput("in_ready8 before accept", 64'(in_ready8), 64'd1);
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        in_signed8 = s;
        @(negedge clk);
        in_valid8  = 1'b0;
        in_a8      = 8'hA5;
        in_b8      = 8'h5A;
    endtask

    task automatic waitDone8(output int k);
        k = 0;
        while (out_valid8 !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic doTxn8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] expRes, input logic expOvf);
        int k;
        out_ready8 = 1'b1;
        applyStimulus8(a, b, s);
        waitDone8(k);
        checkOutput({tag, " latency"}, 64'(k), 64'd8);
        checkOutput({tag, " result"}, 64'(result8), 64'(expRes));
        checkOutput({tag, " overflow"}, 64'(overflow8), 64'(expOvf));
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput({tag, " out_valid one cycle"}, 64'(out_valid8), 64'd0);
        checkOutput({tag, " in_ready returns"}, 64'(in_ready8), 64'd1);
    endtask

    function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [63:0] r, output logic o);
        longint p;
        logic [63:0] up;
        up = 64'(a) * 64'(b);
        r  = up;
        o  = (up > 64'h0000_0000_FFFF_FFFF);
`ifdef SEQ_MULT_SIGNED_EN
        if (s) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p;
            o = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end
`else
        if (s) r = up;
`endif
    endfunction

    initial begin
        int k;
        logic [31:0] a, b;
        logic s;
        logic [63:0] expR;
        logic expO;

        repeat (3) @(negedge clk);
        checkOutput("reset result8", 64'(result8), 64'd0);
        checkOutput("reset overflow8", 64'(overflow8), 64'd0);
        checkOutput("reset out_valid8", 64'(out_valid8), 64'd0);
        checkOutput("reset in_ready8", 64'(in_ready8), 64'd1);
        checkOutput("reset result32", result32, 64'd0);
        checkOutput("reset in_ready32", 64'(in_ready32), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        doTxn8("12x10", 8'd12, 8'd10, 1'b0, 16'h0078, 1'b0);
        doTxn8("255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        doTxn8("0x200", 8'd0, 8'd200, 1'b0, 16'h0000, 1'b0);
        doTxn8("200x0", 8'd200, 8'd0, 1'b0, 16'h0000, 1'b0);
`ifdef SEQ_MULT_SIGNED_EN
        doTxn8("s -3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1, 1'b0);
        doTxn8("s -128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        doTxn8("s -1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        doTxn8("s 100x-2", 8'd100, 8'hFE, 1'b1, 16'hFF38, 1'b1);
        doTxn8("u flag 255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
`else
        doTxn8("in_signed ignored", 8'hFD, 8'd5, 1'b1, 16'h04F1, 1'b1);
`endif

        // Back-pressure: hold the result while a new request waits.
        out_ready8 = 1'b0;
        applyStimulus8(8'd12, 8'd10, 1'b0);
        waitDone8(k);
        checkOutput("bp latency", 64'(k), 64'd8);
        in_valid8 = 1'b1;
        in_a8     = 8'd7;
        in_b8     = 8'd6;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp out_valid held", 64'(out_valid8), 64'd1);
            checkOutput("bp in_ready low", 64'(in_ready8), 64'd0);
            checkOutput("bp result held", 64'(result8), 64'h0078);
            checkOutput("bp overflow held", 64'(overflow8), 64'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput("bp out_valid after handshake", 64'(out_valid8), 64'd0);
        checkOutput("bp in_ready after handshake", 64'(in_ready8), 64'd1);
        @(negedge clk);
        in_valid8 = 1'b0;
        checkOutput("bp pending accepted", 64'(in_ready8), 64'd0);
        waitDone8(k);
        checkOutput("bp second latency", 64'(k), 64'd8);
        checkOutput("bp second result", 64'(result8), 64'h002A);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;

        // Reset during iteration 4 of 12x10.
        applyStimulus8(8'd12, 8'd10, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("pre-reset busy", 64'(in_ready8), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset result", 64'(result8), 64'd0);
        checkOutput("midreset overflow", 64'(overflow8), 64'd0);
        checkOutput("midreset out_valid", 64'(out_valid8), 64'd0);
        checkOutput("midreset in_ready", 64'(in_ready8), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        doTxn8("post-reset 7x6", 8'd7, 8'd6, 1'b0, 16'h002A, 1'b0);

        for (int t = 0; t < 1000; t++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (t % 97 == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
            if (t % 97 == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            if (t % 97 == 2) begin a = 32'd0; end
            if (t % 97 == 3) begin a = 32'd1; b = 32'hFFFF_FFFF; end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput("rand in_ready", 64'(in_ready32), 64'd1);
            in_valid32  = 1'b1;
            in_a32      = a;
            in_b32      = b;
            in_signed32 = s;
            @(negedge clk);
            in_valid32  = 1'b0;
            in_a32      = $urandom;
            in_b32      = $urandom;
            in_signed32 = ~s;
            k = 0;
            while (out_valid32 !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            model32(a, b, s, expR, expO);
            checkOutput("rand latency", 64'(k), 64'd32);
            checkOutput("rand result", result32, expR);
            checkOutput("rand overflow", 64'(overflow32), 64'(expO));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checkOutput("rand held result", result32, expR);
            end
            out_ready32 = 1'b1;
            @(negedge clk);
            out_ready32 = 1'b0;
            checkOutput("rand out_valid drop", 64'(out_valid32), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
